// File: rtl/sid_voice_mixer.sv
// Three-voice SID mixer: envelope-scales each voice through one shared 12x9 multiplier,
// sums the voices, applies master volume and voice-3 mute, and emits one signed 16-bit sample per tick.
module sid_voice_mixer #(
  parameter int OUT_SHIFT = 10,
  parameter bit SATURATE  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sample_tick,
  input  logic [11:0] wave0,
  input  logic [11:0] wave1,
  input  logic [11:0] wave2,
  input  logic [7:0]  env0,
  input  logic [7:0]  env1,
  input  logic [7:0]  env2,
  input  logic [7:0]  mode_vol,
  output logic [15:0] audio_out,
  output logic        audio_valid,
  output logic        busy,
  output logic        overrun
);

  typedef enum logic [2:0] {S_IDLE, S_V0, S_V1, S_V2, S_SCALE} state_t;

  state_t             state_q, state_d;
  logic signed [22:0] acc_q, acc_d;
  logic [11:0]        wave0_q, wave0_d, wave1_q, wave1_d, wave2_q, wave2_d;
  logic [7:0]         env0_q, env0_d, env1_q, env1_d, env2_q, env2_d;
  logic               mute_q, mute_d;
  logic [3:0]         vol_q, vol_d;
  logic [15:0]        audio_out_q, audio_out_d;
  logic               audio_valid_q, audio_valid_d;
  logic               busy_q, busy_d;
  logic               overrun_q, overrun_d;

  logic [11:0]        mul_wave_s;
  logic [7:0]         mul_env_s;
  logic signed [11:0] mul_a_s;
  logic signed [8:0]  mul_b_s;
  logic signed [20:0] prod_s;
  logic signed [22:0] prod_ext_s;
  logic signed [27:0] scaled_s;
  logic signed [27:0] shifted_s;
  logic               unused_mode_bits;

  assign unused_mode_bits = ^mode_vol[6:4];

  function automatic logic [15:0] fmt(input logic signed [27:0] v);
    if (SATURATE) begin
      if (v > 28'sd32767) begin
        return 16'h7FFF;
      end else if (v < -28'sd32768) begin
        return 16'h8000;
      end else begin
        return v[15:0];
      end
    end else begin
      return v[15:0];
    end
  endfunction

  // The single voice multiplier: operands selected by the current voice state.
  always_comb begin
    mul_wave_s = wave0_q;
    mul_env_s  = env0_q;
    case (state_q)
      S_V0:    begin mul_wave_s = wave0_q; mul_env_s = env0_q; end
      S_V1:    begin mul_wave_s = wave1_q; mul_env_s = env1_q; end
      S_V2:    begin mul_wave_s = wave2_q; mul_env_s = env2_q; end
      default: begin mul_wave_s = wave0_q; mul_env_s = env0_q; end
    endcase
    mul_a_s    = $signed({~mul_wave_s[11], mul_wave_s[10:0]});
    mul_b_s    = $signed({1'b0, mul_env_s});
    prod_s     = mul_a_s * mul_b_s;
    prod_ext_s = {{2{prod_s[20]}}, prod_s};
    scaled_s   = $signed({{5{acc_q[22]}}, acc_q}) * $signed({24'd0, vol_q});
    shifted_s  = scaled_s >>> OUT_SHIFT;
  end

  // Next-state logic for the mix sequencer, snapshot and output registers.
  always_comb begin
    state_d       = state_q;
    acc_d         = acc_q;
    wave0_d       = wave0_q;
    wave1_d       = wave1_q;
    wave2_d       = wave2_q;
    env0_d        = env0_q;
    env1_d        = env1_q;
    env2_d        = env2_q;
    mute_d        = mute_q;
    vol_d         = vol_q;
    audio_out_d   = audio_out_q;
    audio_valid_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (sample_tick) begin
          state_d = S_V0;
          acc_d   = 23'sd0;
          wave0_d = wave0;
          wave1_d = wave1;
          wave2_d = wave2;
          env0_d  = env0;
          env1_d  = env1;
          env2_d  = env2;
          mute_d  = mode_vol[7];
          vol_d   = mode_vol[3:0];
        end else begin
          state_d = S_IDLE;
        end
      end
      S_V0: begin
        acc_d   = acc_q + prod_ext_s;
        state_d = S_V1;
      end
      S_V1: begin
        acc_d   = acc_q + prod_ext_s;
        state_d = S_V2;
      end
      S_V2: begin
        if (mute_q) begin
          acc_d = acc_q;
        end else begin
          acc_d = acc_q + prod_ext_s;
        end
        state_d = S_SCALE;
      end
      S_SCALE: begin
        audio_out_d   = fmt(shifted_s);
        audio_valid_d = 1'b1;
        state_d       = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (sample_tick && (state_q != S_IDLE)) begin
      overrun_d = 1'b1;
    end else begin
      overrun_d = 1'b0;
    end
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      acc_q         <= 23'sd0;
      wave0_q       <= 12'h800;
      wave1_q       <= 12'h800;
      wave2_q       <= 12'h800;
      env0_q        <= 8'd0;
      env1_q        <= 8'd0;
      env2_q        <= 8'd0;
      mute_q        <= 1'b0;
      vol_q         <= 4'd0;
      audio_out_q   <= 16'd0;
      audio_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      wave0_q       <= wave0_d;
      wave1_q       <= wave1_d;
      wave2_q       <= wave2_d;
      env0_q        <= env0_d;
      env1_q        <= env1_d;
      env2_q        <= env2_d;
      mute_q        <= mute_d;
      vol_q         <= vol_d;
      audio_out_q   <= audio_out_d;
      audio_valid_q <= audio_valid_d;
      busy_q        <= busy_d;
      overrun_q     <= overrun_d;
    end
  end

  assign audio_out   = audio_out_q;
  assign audio_valid = audio_valid_q;
  assign busy        = busy_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_sid_voice_mixer.sv
// Directed bench for sid_voice_mixer: scoreboard of expected samples checked when audio_valid fires,
// plus a second instance with OUT_SHIFT=0 to exercise saturation.
module tb_sid_voice_mixer;

  typedef struct {
    logic signed [15:0] exp;
    int                 due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sample_tick = 1'b0;
  logic [11:0] wave0 = 12'h800, wave1 = 12'h800, wave2 = 12'h800;
  logic [7:0]  env0 = 8'd0, env1 = 8'd0, env2 = 8'd0;
  logic [7:0]  mode_vol = 8'h00;
  logic [15:0] audio_out, audio_out2;
  logic        audio_valid, audio_valid2;
  logic        busy, busy2;
  logic        overrun, overrun2;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   valid_cnt = 0;
  int   ovr_cnt = 0;
  logic prev_valid = 1'b0;
  exp_t q1[$];
  exp_t q2[$];

  sid_voice_mixer dut (
    .clk(clk), .rst(rst), .sample_tick(sample_tick),
    .wave0(wave0), .wave1(wave1), .wave2(wave2),
    .env0(env0), .env1(env1), .env2(env2), .mode_vol(mode_vol),
    .audio_out(audio_out), .audio_valid(audio_valid), .busy(busy), .overrun(overrun)
  );

  sid_voice_mixer #(.OUT_SHIFT(0), .SATURATE(1'b1)) dut2 (
    .clk(clk), .rst(rst), .sample_tick(sample_tick),
    .wave0(wave0), .wave1(wave1), .wave2(wave2),
    .env0(env0), .env1(env1), .env2(env2), .mode_vol(mode_vol),
    .audio_out(audio_out2), .audio_valid(audio_valid2), .busy(busy2), .overrun(overrun2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic signed [15:0] model(input logic [11:0] w0, input logic [11:0] w1,
                                               input logic [11:0] w2, input logic [7:0] e0,
                                               input logic [7:0] e1, input logic [7:0] e2,
                                               input logic [7:0] mv, input int sh);
    longint acc;
    longint r;
    acc = (longint'(w0) - 2048) * longint'(e0) + (longint'(w1) - 2048) * longint'(e1);
    if (!mv[7]) acc = acc + (longint'(w2) - 2048) * longint'(e2);
    r = (acc * longint'(mv[3:0])) >>> sh;
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    return 16'(r);
  endfunction

  // Scoreboard side: compare each produced sample against the oldest expectation.
  always @(negedge clk) begin
    if (audio_valid) begin
      valid_cnt++;
      check("valid_back_to_back", 32'(prev_valid), 32'sd0);
      if (q1.size() == 0) begin
        check("stray_valid", 32'sd1, 32'sd0);
      end else begin
        exp_t e;
        e = q1.pop_front();
        check("audio_out", 32'(signed'(audio_out)), 32'(e.exp));
        check("latency", cyc, e.due);
      end
    end
    if (audio_valid2) begin
      if (q2.size() == 0) begin
        check("stray_valid_sat", 32'sd1, 32'sd0);
      end else begin
        exp_t e;
        e = q2.pop_front();
        check("audio_out_sat", 32'(signed'(audio_out2)), 32'(e.exp));
      end
    end
    if (overrun) ovr_cnt++;
    prev_valid = audio_valid;
  end

  task automatic set_inputs(input logic [11:0] w0, input logic [11:0] w1, input logic [11:0] w2,
                            input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2,
                            input logic [7:0] mv);
    wave0 = w0; wave1 = w1; wave2 = w2;
    env0 = e0; env1 = e1; env2 = e2; mode_vol = mv;
  endtask

  // Pulses sample_tick for one cycle; an accepted tick queues its expected samples.
  task automatic tick(input bit accepted);
    exp_t e;
    if (accepted) begin
      e.due = cyc + 5;
      e.exp = model(wave0, wave1, wave2, env0, env1, env2, mode_vol, 10);
      q1.push_back(e);
      e.exp = model(wave0, wave1, wave2, env0, env1, env2, mode_vol, 0);
      q2.push_back(e);
    end
    sample_tick = 1'b1;
    @(posedge clk); #1;
    sample_tick = 1'b0;
  endtask

  task automatic wait_done();
    bit done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (q1.size() == 0 && q2.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    check("pass_completes", 32'(done), 32'sd1);
  endtask

  initial begin
    int v0, o0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_audio_out", 32'(audio_out), 32'sd0);
    check("reset_valid", 32'(audio_valid), 32'sd0);
    check("reset_busy", 32'(busy), 32'sd0);
    check("reset_overrun", 32'(overrun), 32'sd0);

    // Single voice, full positive, with busy profile.
    set_inputs(12'hFFF, 12'h800, 12'h800, 8'd255, 8'd255, 8'd255, 8'h0F);
    tick(1'b1);
    for (int i = 0; i < 4; i++) begin
      check("busy_during_pass", 32'(busy), 32'sd1);
      if (i < 3) begin
        @(posedge clk); #1;
      end
    end
    wait_done();
    check("busy_after_pass", 32'(busy), 32'sd0);
    check("single_voice_7646", 32'(signed'(audio_out)), 32'sd7646);
    check("single_voice_sat", 32'(signed'(audio_out2)), 32'sd32767);

    // All voices at full negative.
    set_inputs(12'h000, 12'h000, 12'h000, 8'd255, 8'd255, 8'd255, 8'h0F);
    tick(1'b1);
    wait_done();
    check("all_neg_-22950", 32'(signed'(audio_out)), -32'sd22950);
    check("all_neg_sat_-32768", 32'(signed'(audio_out2)), -32'sd32768);

    mode_vol = 8'h8F;
    tick(1'b1);
    wait_done();
    check("voice3_off_-15300", 32'(signed'(audio_out)), -32'sd15300);

    v0 = valid_cnt;
    mode_vol = 8'h00;
    tick(1'b1);
    wait_done();
    check("vol0_zero", 32'(signed'(audio_out)), 32'sd0);
    check("vol0_valid_pulse", valid_cnt - v0, 32'sd1);

    set_inputs(12'h123, 12'hABC, 12'h7FF, 8'd17, 8'd200, 8'd99, 8'h09);
    tick(1'b1);
    wait_done();

    // Second tick while busy is dropped and flagged.
    v0 = valid_cnt; o0 = ovr_cnt;
    set_inputs(12'hC00, 12'h400, 12'hE55, 8'd128, 8'd64, 8'd250, 8'h0C);
    tick(1'b1);
    @(posedge clk); #1;
    tick(1'b0);
    wait_done();
    repeat (4) @(posedge clk);
    #1;
    check("overrun_one_valid", valid_cnt - v0, 32'sd1);
    check("overrun_one_pulse", ovr_cnt - o0, 32'sd1);

    // Back-to-back ticks at the minimum spacing.
    v0 = valid_cnt; o0 = ovr_cnt;
    for (int k = 0; k < 4; k++) begin
      wave0 = 12'(12'h100 * k + 12'h0F0);
      env1  = 8'(8'd40 * k + 8'd7);
      mode_vol = 8'(8'h80 * (k % 2) + 8'h0F - k);
      tick(1'b1);
      repeat (4) @(posedge clk);
      #1;
    end
    wait_done();
    check("spaced_valids", valid_cnt - v0, 32'sd4);
    check("spaced_no_overrun", ovr_cnt - o0, 32'sd0);

    // Snapshot holds after the tick edge.
    set_inputs(12'hFFF, 12'h800, 12'h800, 8'd255, 8'd255, 8'd255, 8'h0F);
    tick(1'b1);
    wave0 = 12'h800;
    env0  = 8'd3;
    mode_vol = 8'h80;
    wait_done();
    check("snapshot_7646", 32'(signed'(audio_out)), 32'sd7646);

    // Reset mid-pass aborts without producing a sample.
    set_inputs(12'h000, 12'h000, 12'h000, 8'd255, 8'd255, 8'd255, 8'h0F);
    v0 = valid_cnt;
    tick(1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    q1.delete();
    q2.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("midreset_audio_out", 32'(audio_out), 32'sd0);
    check("midreset_valid", 32'(audio_valid), 32'sd0);
    check("midreset_busy", 32'(busy), 32'sd0);
    check("midreset_overrun", 32'(overrun), 32'sd0);
    repeat (8) @(posedge clk);
    #1;
    check("midreset_no_valid", valid_cnt - v0, 32'sd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
